// File: rtl/sop_eval.sv
// sop_eval -- programmable sum-of-products evaluator with truth-table sweep.
//
// Holds T product terms over an N-bit argument. Term i matches argument a
// when on_i = 1 and every cared bit of a equals the stored value bit.
// z is the OR of all matching terms (0 when no term is enabled).
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   load_en/idx/care/val/on term slot write (ignored during a sweep or
//                           when load_idx >= T)
//   in_valid/in_ready/x     argument stream in
//   out_valid/out_ready     result stream out, payload {z, x_out}
//   sweep_start             enumerate all 2^N arguments in order
//   sweep_busy              high while the sweep runs (this is the FSM state)
//   sweep_done              one-cycle pulse after the last beat is accepted
//
// Handshake: a transfer happens at a rising edge where valid and ready are
// both 1. out_valid/z/x_out hold stable while out_valid & !out_ready.
// in_ready does not depend on in_valid.
module sop_eval #(
  parameter int N = 4,
  parameter int T = 8,
  localparam int TW = (T > 1) ? $clog2(T) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_en,
  input  logic [TW-1:0] load_idx,
  input  logic [N-1:0]  load_care,
  input  logic [N-1:0]  load_val,
  input  logic          load_on,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  x,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          z,
  output logic [N-1:0]  x_out,
  input  logic          sweep_start,
  output logic          sweep_busy,
  output logic          sweep_done
);

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  state_t       r_state;
  state_t       w_state_nxt;

  logic [N-1:0] r_care [T];
  logic [N-1:0] r_val  [T];
  logic [T-1:0] r_on;

  // One extra bit so the counter reaches 2^N after the last beat is loaded
  // instead of wrapping back to 0.
  logic [N:0]   r_cnt;
  logic [N:0]   w_cnt_nxt;

  logic         r_out_valid;
  logic         r_z;
  logic [N-1:0] r_x_out;
  logic         r_done;
  logic         w_done_nxt;

  logic         w_idle;
  logic         w_drain_ok;
  logic         w_in_ready;
  logic         w_in_fire;
  logic         w_beat_fire;
  logic         w_last_acc;
  logic         w_load_ok;
  logic [N-1:0] w_arg;
  logic         w_z;

  assign w_idle     = (r_state == IDLE);
  // Output register can take a new entry: empty, or drained at this edge.
  assign w_drain_ok = !r_out_valid || out_ready;
  // sweep_start wins over a same-cycle argument; during reset the block
  // advertises ready.
  assign w_in_ready = !rst_n || (w_idle && w_drain_ok && !sweep_start);
  assign w_in_fire  = in_valid && w_in_ready;
  // A sweep beat is produced until the counter has passed 2^N-1.
  assign w_beat_fire = !w_idle && w_drain_ok && !r_cnt[N];
  // Counter at 2^N means the register holds the final beat.
  assign w_last_acc  = !w_idle && r_cnt[N] && r_out_valid && out_ready;
  assign w_load_ok   = load_en && w_idle && (32'(load_idx) < 32'(T));

  assign w_arg = w_idle ? x : r_cnt[N-1:0];

  always_comb begin
    w_z = 1'b0;
    for (int i = 0; i < T; i++) begin
      if (r_on[i] && (((w_arg ^ r_val[i]) & r_care[i]) == '0)) begin
        w_z = 1'b1;
      end
    end
  end

  // FSM next state and counter.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_done_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (sweep_start) begin
          w_state_nxt = SWEEP;
          w_cnt_nxt   = '0;
        end
      end
      SWEEP: begin
        if (w_beat_fire) begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
        if (w_last_acc) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
          w_done_nxt  = 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Term table.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_on <= '0;
      for (int i = 0; i < T; i++) begin
        r_care[i] <= '0;
        r_val[i]  <= '0;
      end
    end else if (w_load_ok) begin
      r_on[load_idx]   <= load_on;
      r_care[load_idx] <= load_care;
      r_val[load_idx]  <= load_val;
    end
  end

  // Output register, fed from the argument stream (IDLE) or counter (SWEEP).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_z         <= 1'b0;
      r_x_out     <= '0;
    end else if (w_in_fire || w_beat_fire) begin
      r_out_valid <= 1'b1;
      r_z         <= w_z;
      r_x_out     <= w_arg;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign in_ready   = w_in_ready;
  assign out_valid  = r_out_valid;
  assign z          = r_z;
  assign x_out      = r_x_out;
  assign sweep_busy = !w_idle;
  assign sweep_done = r_done;

endmodule

// File: tb/tb_sop_eval.sv
module tb_sop_eval;
  localparam int N  = 4;
  localparam int T  = 6;
  localparam int TW = 3;
  localparam int NV = 16;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst_n;
  logic          load_en;
  logic [TW-1:0] load_idx;
  logic [N-1:0]  load_care;
  logic [N-1:0]  load_val;
  logic          load_on;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  x;
  logic          out_valid;
  logic          out_ready;
  logic          z;
  logic [N-1:0]  x_out;
  logic          sweep_start;
  logic          sweep_busy;
  logic          sweep_done;

  always #5 clk = ~clk;

  sop_eval #(.N(N), .T(T)) dut (
    .clk(clk), .rst_n(rst_n),
    .load_en(load_en), .load_idx(load_idx), .load_care(load_care),
    .load_val(load_val), .load_on(load_on),
    .in_valid(in_valid), .in_ready(in_ready), .x(x),
    .out_valid(out_valid), .out_ready(out_ready), .z(z), .x_out(x_out),
    .sweep_start(sweep_start), .sweep_busy(sweep_busy), .sweep_done(sweep_done)
  );

  // ---------------- scoreboard / reference model ----------------
  int           n_cmp = 0;
  int           n_fail = 0;
  logic [N:0]   exp_q[$];     // {z, x_out}
  int           arg_q[$];
  logic [N-1:0] m_care [T];
  logic [N-1:0] m_val  [T];
  logic         m_on   [T];
  logic [NV-1:0] obs_mask;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Function value from the term list: some enabled term whose cared bits
  // all agree with the argument.
  function automatic logic model_z(input int a);
    for (int t = 0; t < T; t++) begin
      if (m_on[t]) begin
        bit agree = 1'b1;
        for (int b = 0; b < N; b++) begin
          if (m_care[t][b] && (((a >> b) & 1) != int'(m_val[t][b]))) agree = 1'b0;
        end
        if (agree) return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  task automatic clear_model();
    for (int t = 0; t < T; t++) begin
      m_on[t] = 1'b0; m_care[t] = '0; m_val[t] = '0;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic load_term(input int idx, input int care, input int val, input bit on);
    @(negedge clk);
    load_en = 1'b1; load_idx = TW'(idx); load_care = N'(care);
    load_val = N'(val); load_on = on;
    @(negedge clk);
    load_en = 1'b0;
    if (idx < T) begin
      m_on[idx] = on; m_care[idx] = N'(care); m_val[idx] = N'(val);
    end
  endtask

  // rnd = 0: in_valid and out_ready held at 1, 1-cycle latency checked.
  task automatic run_stream(input bit rnd);
    int n = arg_q.size();
    int got = 0;
    int guard = 0;
    exp_q.delete();
    while (got < n && guard < 2000) begin
      @(negedge clk);
      guard++;
      if (out_valid) begin
        if (exp_q.size() == 0) chk("stream_spurious", out_valid, 0);
        else chk("stream_res", {z, x_out}, exp_q[0]);
      end else if (!rnd && exp_q.size() != 0) begin
        chk("stream_lat", out_valid, 1);
      end
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (arg_q.size() != 0 && (!rnd || $urandom_range(0, 3) != 0)) begin
        in_valid = 1'b1; x = N'(arg_q[0]);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (rnd) chk("in_ready_rule", in_ready, !out_valid || out_ready);
      else if (in_valid) chk("in_ready_free", in_ready, 1);
      if (out_valid && out_ready) begin
        void'(exp_q.pop_front());
        got++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back({model_z(int'(x)), x});
        void'(arg_q.pop_front());
      end
    end
    in_valid = 1'b0;
    chk("stream_count", got, n);
  endtask

  // pat 0: out_ready=1, 1: ready pattern 1,0,0,..., 2: random.
  // abort_x >= 0: pulse reset while beat abort_x is on the output.
  // inj: attempt term loads while the sweep runs.
  task automatic run_sweep(input int pat, input int abort_x, input bit inj);
    int it = 0;
    int done_cnt = 0;
    bit aborted = 1'b0;
    exp_q.delete();
    obs_mask = '0;
    for (int a = 0; a < NV; a++) exp_q.push_back({model_z(a), N'(a)});
    @(negedge clk);
    sweep_start = 1'b1; out_ready = 1'b1;
    #1;
    chk("start_prio", in_ready, 0);
    @(negedge clk);
    sweep_start = 1'b0;
    chk("busy_start", sweep_busy, 1);
    chk("first_not_yet", out_valid, 0);
    while (it < 400) begin
      @(negedge clk);
      it++;
      load_en = 1'b0;
      if (sweep_done) begin
        done_cnt++;
        chk("done_after_last", exp_q.size(), 0);
        if (pat == 0) chk("done_lat", it, NV + 1);
        break;
      end
      chk("busy", sweep_busy, 1);
      if (out_valid) begin
        if (exp_q.size() == 0) chk("sweep_spurious", out_valid, 0);
        else chk("sweep_beat", {z, x_out}, exp_q[0]);
      end
      if (pat == 0) chk("sweep_tput", out_valid, 1);
      if (abort_x >= 0 && out_valid && int'(x_out) == abort_x) begin
        rst_n = 1'b0;
        #1;
        chk("abort_valid", out_valid, 0);
        chk("abort_busy", sweep_busy, 0);
        chk("abort_z", {z, x_out}, 0);
        chk("abort_in_ready", in_ready, 1);
        clear_model();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_no_done", sweep_done, 0);
        @(negedge clk);
        chk("abort_no_done2", sweep_done, 0);
        aborted = 1'b1;
        break;
      end
      case (pat)
        0:       out_ready = 1'b1;
        1:       out_ready = (it % 3 == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (inj && it == 2) begin
        load_en = 1'b1; load_idx = 3'd0; load_care = '0; load_val = '0; load_on = 1'b0;
      end
      if (inj && it == 3) begin
        load_en = 1'b1; load_idx = TW'(T); load_care = '0; load_val = '0; load_on = 1'b1;
      end
      #1;
      if (out_valid && out_ready) begin
        obs_mask[x_out] = z;
        void'(exp_q.pop_front());
      end
    end
    load_en = 1'b0;
    out_ready = 1'b1;
    if (!aborted) begin
      chk("done_once", done_cnt, 1);
      @(negedge clk);
      chk("done_pulse", sweep_done, 0);
      chk("busy_end", sweep_busy, 0);
      chk("empty_end", out_valid, 0);
    end
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    rst_n = 1'b0; load_en = 1'b0; load_idx = '0; load_care = '0; load_val = '0;
    load_on = 1'b0; in_valid = 1'b0; x = '0; out_ready = 1'b1; sweep_start = 1'b0;
    clear_model();
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_z_x", {z, x_out}, 0);
    chk("rst_busy", sweep_busy, 0);
    chk("rst_done", sweep_done, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", in_ready, 1);

    // Empty table sweep.
    run_sweep(0, -1, 1'b0);
    chk("empty_mask", obs_mask, 16'h0000);

    // Three-term function: ones at 0, 2, 6, 7, 9, 11.
    load_term(0, 4'b1101, 4'b0000, 1'b1);
    load_term(1, 4'b1101, 4'b1001, 1'b1);
    load_term(2, 4'b1110, 4'b0110, 1'b1);
    run_sweep(0, -1, 1'b0);
    chk("func_mask", obs_mask, 16'h0AC5);

    arg_q = '{9, 3, 6};
    run_stream(1'b0);

    // Backpressure sweep.
    run_sweep(1, -1, 1'b0);
    chk("bp_mask", obs_mask, 16'h0AC5);

    // Loads during a sweep are ignored.
    run_sweep(0, -1, 1'b1);
    chk("inj_mask", obs_mask, 16'h0AC5);

    // Out-of-range slot index is ignored while idle too.
    load_term(T, 4'b0000, 4'b0000, 1'b1);
    arg_q = '{3, 4, 5, 8};
    run_stream(1'b0);

    // Don't-care term: constant 1.
    load_term(0, 4'b0000, 4'b0000, 1'b1);
    run_sweep(0, -1, 1'b0);
    chk("const1_mask", obs_mask, 16'hFFFF);

    // Reset mid-sweep, then everything reads 0.
    run_sweep(0, 5, 1'b0);
    run_sweep(0, -1, 1'b0);
    chk("post_abort_mask", obs_mask, 16'h0000);

    // Random terms, random stream, random-backpressure sweep.
    for (int k = 0; k < 12; k++) begin
      load_term($urandom_range(0, 7), $urandom_range(0, NV - 1),
                $urandom_range(0, NV - 1), $urandom_range(0, 3) != 0);
    end
    for (int k = 0; k < 40; k++) arg_q.push_back($urandom_range(0, NV - 1));
    run_stream(1'b1);
    run_sweep(2, -1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
